// File: rtl/rr_grant_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_encoder_pkg
//  Description : Shared definitions for the round-robin grant encoder and its
//                bench. It holds the requester count, the index width, the FSM
//                state encodings, the grant counter width and a modulo-16
//                increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package rr_grant_encoder_pkg;

    localparam int N     = 16;   // requesters, one per decoder output
    localparam int W     = 4;    // log2(N), width of the granted index
    localparam int CNT_W = 8;    // grant-hold counter width (saturating)

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // Index arithmetic is modulo N; a W-bit add wraps 15 -> 0 on its own.
    function automatic logic [W-1:0] idx_inc(input logic [W-1:0] v);
        return v + W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_encoder_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin pick. It rotates req right by ptr
//                and priority-encodes the lowest set bit. It then adds ptr back
//                modulo 16, so the search order is ptr, ptr+1, ... wrapping.
//  Ports       : req [15:0] in   request vector
//                ptr [3:0]  in   search start index
//                idx [3:0]  out  selected requester (valid when any=1)
//                any        out  at least one request is pending
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import rr_grant_encoder_pkg::*;
(
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] w_rot;
    logic [W-1:0] w_enc;

    // w_rot[i] = req[(i + ptr) mod 16]; the W-bit add provides the wrap.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign w_rot[gi] = req[W'(gi) + ptr];
    end

    // Lowest set bit of the rotated vector wins: scan high to low so the
    // last hit is the lowest index.
    always_comb begin
        w_enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = W'(i);
            end
        end
    end

    assign idx = w_enc + ptr;
    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/rr_grant_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_encoder
//  Description : Round-robin arbiter over 16 requesters. It drives the index and
//                enable of a downstream 4-to-16 decoder. A grant is held until
//                done, or until an optional timeout force-releases it.
//  Ports       : clk        in   clock, all state on posedge
//                rst        in   synchronous active-high reset
//                req [15:0] in   request vector
//                done       in   owner releases grant (GRANT state only)
//                w   [3:0]  out  granted index, registered
//                En         out  grant valid, registered
//                tmo        out  one-cycle pulse on timeout release
//  Revision    : 1.0  initial release
// ============================================================================
module rr_grant_encoder
    import rr_grant_encoder_pkg::*;
#(
    parameter int TIMEOUT = 0        // 0 = no timeout, else 1..255 cycles
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [W-1:0] w,
    output logic         En,
    output logic         tmo
);

    logic [0:0]       r_state, w_state_nxt;
    logic [W-1:0]     r_ptr,   w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [W-1:0]     r_w,     w_w_nxt;
    logic             r_en,    w_en_nxt;
    logic             r_tmo,   w_tmo_nxt;

    logic [W-1:0]     w_pick_idx;
    logic             w_pick_any;
    logic             w_tmo_hit;

    rr_pick u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // The timeout fires while the grant is in its last allowed cycle.
    if (TIMEOUT != 0) begin : g_tmo_on
        localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT - 1);
        assign w_tmo_hit = (r_cnt == c_tmo_last);
    end else begin : g_tmo_off
        assign w_tmo_hit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_w     <= '0;
            r_en    <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_w     <= w_w_nxt;
            r_en    <= w_en_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_w_nxt     = r_w;      // w keeps the last grant while En is low
        w_en_nxt    = r_en;
        w_tmo_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // done is ignored here; only requests matter.
                w_en_nxt = 1'b0;
                if (w_pick_any) begin
                    w_w_nxt     = w_pick_idx;
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // req is ignored while a grant is held. done takes priority
                // over a coincident timeout, so tmo stays low in that case.
                if (done) begin
                    w_en_nxt    = 1'b0;
                    w_ptr_nxt   = idx_inc(r_w);
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_en_nxt    = 1'b0;
                    w_tmo_nxt   = 1'b1;
                    w_ptr_nxt   = idx_inc(r_w);
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    assign w   = r_w;
    assign En  = r_en;
    assign tmo = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_grant_encoder
//  Description : Directed bench for rr_grant_encoder. It uses a per-cycle vector
//                table against an instance with no timeout. Hand-written
//                sequences exercise the timeout instance (TIMEOUT=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_grant_encoder;
    import rr_grant_encoder_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_nt = '0, req_to = '0;
    logic         done_nt = 1'b0, done_to = 1'b0;
    logic [W-1:0] w_nt, w_to;
    logic         en_nt, en_to, tmo_nt, tmo_to;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_grant_encoder #(.TIMEOUT(0)) dut_nt (
        .clk (clk), .rst (rst), .req (req_nt), .done (done_nt),
        .w (w_nt), .En (en_nt), .tmo (tmo_nt)
    );

    rr_grant_encoder #(.TIMEOUT(4)) dut_to (
        .clk (clk), .rst (rst), .req (req_to), .done (done_to),
        .w (w_to), .En (en_to), .tmo (tmo_to)
    );

    typedef struct packed {
        logic         rst;
        logic [N-1:0] req;
        logic         done;
        logic         en;
        logic [W-1:0] w;
        logic         tmo;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_to(input string nm, input logic en, input logic [W-1:0] wv, input logic t);
        check({nm, " En"},  16'(en_to),  16'(en));
        check({nm, " w"},   16'(w_to),   16'(wv));
        check({nm, " tmo"}, 16'(tmo_to), 16'(t));
    endtask

    initial begin
        //            rst  req       done  En  w      tmo
        tbl[0]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0,  1'b0};
        tbl[1]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0,  1'b0};
        tbl[2]  = '{1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd0,  1'b0}; // first grant w=0
        tbl[3]  = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0,  1'b0};
        tbl[4]  = '{1'b1, 16'h0028, 1'b0, 1'b0, 4'd0,  1'b0}; // ptr back to 0
        tbl[5]  = '{1'b0, 16'h0028, 1'b0, 1'b1, 4'd3,  1'b0};
        tbl[6]  = '{1'b0, 16'h0028, 1'b0, 1'b1, 4'd3,  1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd3,  1'b0}; // owner drops req
        tbl[8]  = '{1'b0, 16'h0028, 1'b1, 1'b0, 4'd3,  1'b0}; // ptr=4
        tbl[9]  = '{1'b0, 16'h0028, 1'b0, 1'b1, 4'd5,  1'b0};
        tbl[10] = '{1'b0, 16'h0028, 1'b1, 1'b0, 4'd5,  1'b0}; // ptr=6
        tbl[11] = '{1'b0, 16'hFFFF, 1'b1, 1'b1, 4'd6,  1'b0}; // done in IDLE ignored
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd6,  1'b0}; // ptr=7
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd6,  1'b0}; // idle, w held
        tbl[14] = '{1'b0, 16'h8000, 1'b0, 1'b1, 4'd15, 1'b0};
        tbl[15] = '{1'b0, 16'h8001, 1'b1, 1'b0, 4'd15, 1'b0}; // ptr wraps to 0
        tbl[16] = '{1'b0, 16'h8001, 1'b0, 1'b1, 4'd0,  1'b0};
        tbl[17] = '{1'b0, 16'h8001, 1'b1, 1'b0, 4'd0,  1'b0}; // ptr=1
        tbl[18] = '{1'b0, 16'h8001, 1'b0, 1'b1, 4'd15, 1'b0};
        tbl[19] = '{1'b0, 16'h8001, 1'b1, 1'b0, 4'd15, 1'b0}; // ptr=0
        tbl[20] = '{1'b0, 16'h0200, 1'b0, 1'b1, 4'd9,  1'b0};
        tbl[21] = '{1'b0, 16'h0200, 1'b0, 1'b1, 4'd9,  1'b0};
        tbl[22] = '{1'b1, 16'h0200, 1'b0, 1'b0, 4'd0,  1'b0}; // rst mid-grant
        tbl[23] = '{1'b0, 16'h0200, 1'b0, 1'b1, 4'd9,  1'b0};
        tbl[24] = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b0};

        for (int i = 0; i < NV; i++) begin
            rst     = tbl[i].rst;
            req_nt  = tbl[i].req;
            done_nt = tbl[i].done;
            tick();
            check($sformatf("row%0d En", i),  16'(en_nt),  16'(tbl[i].en));
            check($sformatf("row%0d w", i),   16'(w_nt),   16'(tbl[i].w));
            check($sformatf("row%0d tmo", i), 16'(tmo_nt), 16'(tbl[i].tmo));
            if (tbl[i].rst) begin
                check($sformatf("row%0d to_En rst", i), 16'(en_to), 16'h0);
            end
        end

        // A long grant with no timeout configured must never be released.
        rst     = 1'b0;
        done_nt = 1'b0;
        req_nt  = 16'h0001;
        tick();
        check("nt long grant start", 16'(en_nt), 16'h1);
        req_nt = 16'h0000;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("nt hold%0d En", k),  16'(en_nt),  16'h1);
            check($sformatf("nt hold%0d tmo", k), 16'(tmo_nt), 16'h0);
        end
        done_nt = 1'b1;
        tick();
        check("nt long grant release", 16'(en_nt), 16'h0);
        done_nt = 1'b0;

        // Timeout: En high for exactly 4 cycles, then tmo pulses as En falls.
        req_to  = 16'h0040;
        done_to = 1'b0;
        tick();
        check_to("to grant", 1'b1, 4'd6, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check_to($sformatf("to hold%0d", k), 1'b1, 4'd6, 1'b0);
        end
        tick();
        check_to("to release", 1'b0, 4'd6, 1'b1);
        tick();
        check_to("to regrant", 1'b1, 4'd6, 1'b0);   // tmo is a single pulse

        // done coincides with the timeout cycle (cnt=3): done wins, no tmo.
        for (int k = 1; k < 4; k++) begin
            tick();
            check_to($sformatf("co hold%0d", k), 1'b1, 4'd6, 1'b0);
        end
        done_to = 1'b1;
        tick();
        check_to("co release", 1'b0, 4'd6, 1'b0);
        done_to = 1'b0;
        req_to  = 16'h0000;
        tick();
        check_to("co idle", 1'b0, 4'd6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
